// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
package seg_scan_ctrl_pkg;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // All segments dark (segments are active-high).
  localparam logic [6:0] SEG_DARK = 7'b0000000;

  // All digit enables released (enables are active-low); sliced to NDIG by users.
  localparam logic [7:0] AN_OFF = 8'hFF;

  // True when a 4-bit digit is not a valid BCD code.
  function automatic logic is_non_bcd(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_dec7seg.sv
// BCD to 7-segment decoder, segments ordered {A,B,C,D,E,F,G}, active-high.
// Codes A-F decode to dark.
module seg_scan_ctrl_dec7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; the caller registers the result.
  always_comb begin
    seg = 7'b0000000;
    case (bcd)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// One shared decoder is steered by the digit index; a one-cycle dark gap
// separates digits to suppress ghosting. All outputs are registered and are
// computed from next-state values so they move on the same edge as the state.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD,
  input  logic [4*NDIG-1:0] DIN,
  input  logic              BLANK_EN,
  output logic              ACK,
  output logic [NDIG-1:0]   AN,
  output logic [6:0]        SEG,
  output logic              ERR
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = $clog2(SCAN_DIV);

  state_t            state, state_next;
  logic [IW-1:0]     idx, idx_next;
  logic [PW-1:0]     pre, pre_next;
  logic [4*NDIG-1:0] disp, disp_next;

  logic [3:0]        digit_next [NDIG];
  logic [NDIG-1:0]   bad_digit;
  logic [NDIG-1:0]   hi_zero;
  logic              zero_run;
  logic [3:0]        dec_in;
  logic [6:0]        dec_seg;
  logic [NDIG-1:0]   an_next;
  logic [6:0]        seg_next;
  logic              err_next;

  // A load is visible to the decode path on the same edge it is captured.
  assign disp_next = LOAD ? DIN : disp;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign digit_next[gi] = disp_next[4*gi +: 4];
      assign bad_digit[gi]  = is_non_bcd(digit_next[gi]);
    end
  endgenerate

  assign err_next = |bad_digit;

  // hi_zero[i] is set when digits i..NDIG-1 are all zero (leading-zero run).
  always_comb begin
    hi_zero  = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run   = zero_run && (digit_next[i] == 4'd0);
      hi_zero[i] = zero_run;
    end
  end

  // Scan sequencer: OFF until first load, then SHOW for SCAN_DIV cycles and GAP for one.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    pre_next   = pre;
    case (state)
      ST_OFF: begin
        if (LOAD) begin
          state_next = ST_SHOW;
          idx_next   = '0;
          pre_next   = '0;
        end
      end
      ST_SHOW: begin
        if (pre == PW'(SCAN_DIV - 1)) begin
          state_next = ST_GAP;
          pre_next   = '0;
        end else begin
          pre_next = pre + PW'(1);
        end
      end
      ST_GAP: begin
        state_next = ST_SHOW;
        idx_next   = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      end
      default: begin
        state_next = ST_OFF;
        idx_next   = '0;
        pre_next   = '0;
      end
    endcase
  end

  // The single shared decoder looks at the digit that will be lit next cycle.
  assign dec_in = digit_next[idx_next];

  seg_scan_ctrl_dec7seg u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  // Drive pattern for the next cycle: one anode low while showing, blanking leading zeros.
  always_comb begin
    an_next  = AN_OFF[NDIG-1:0];
    seg_next = SEG_DARK;
    if (state_next == ST_SHOW) begin
      an_next[idx_next] = 1'b0;
      if (!(BLANK_EN && (idx_next != '0) && hi_zero[idx_next])) begin
        seg_next = dec_seg;
      end
    end
  end

  // State, counters, display register and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_OFF;
      idx   <= '0;
      pre   <= '0;
      disp  <= '0;
      AN    <= AN_OFF[NDIG-1:0];
      SEG   <= SEG_DARK;
      ACK   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      pre   <= pre_next;
      disp  <= disp_next;
      AN    <= an_next;
      SEG   <= seg_next;
      ACK   <= LOAD;
      ERR   <= err_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, SCAN_DIV=4 (20-cycle frame).
// phase tracks position in the frame: digit = phase/5, slot 4 of each digit is the gap.
module tb_seg_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SD = 7'b0000000;

  logic        CLK;
  logic        RST_N;
  logic        LOAD;
  logic [15:0] DIN;
  logic        BLANK_EN;
  logic        ACK;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        ERR;

  int vectors     = 0;
  int miscompares = 0;
  int phase       = 0;

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .LOAD     (LOAD),
    .DIN      (DIN),
    .BLANK_EN (BLANK_EN),
    .ACK      (ACK),
    .AN       (AN),
    .SEG      (SEG),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (phase %0d)", tag, obs, exp, phase);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    phase = (phase + 1) % 20;
  endtask

  task automatic check_dark(input string tag);
    chk({tag, ".an"},  16'(AN),  16'hF);
    chk({tag, ".seg"}, 16'(SEG), 16'h0);
    chk({tag, ".ack"}, 16'(ACK), 16'h0);
    chk({tag, ".err"}, 16'(ERR), 16'h0);
  endtask

  // segs[i] is the hand-decoded pattern expected while digit i is lit.
  task automatic check_cycle(input string tag, input logic [3:0][6:0] segs,
                             input logic err, input logic ack);
    int d, pos;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    d   = phase / 5;
    pos = phase % 5;
    if (pos == 4) begin
      exp_an  = 4'hF;
      exp_seg = SD;
    end else begin
      exp_an  = ~(4'b0001 << d);
      exp_seg = segs[d];
    end
    chk({tag, ".an"},  16'(AN),  16'(exp_an));
    chk({tag, ".seg"}, 16'(SEG), 16'(exp_seg));
    chk({tag, ".ack"}, 16'(ACK), 16'(ack));
    chk({tag, ".err"}, 16'(ERR), 16'(err));
  endtask

  task automatic frame(input string tag, input logic [3:0][6:0] segs,
                       input logic err, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_cycle(tag, segs, err, 1'b0);
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    LOAD     = 1'b0;
    DIN      = 16'h0;
    BLANK_EN = 1'b0;

    // Reset held for 3 cycles, then 20 idle cycles: display must stay dark.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_dark("rst_hold");
    end
    RST_N = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_dark("idle");
    end

    // Basic scan of 1234: digit 0 lit the cycle after LOAD, full frame, digit 0 again.
    DIN  = 16'h1234;
    LOAD = 1'b1;
    tick();
    LOAD  = 1'b0;
    phase = 0;
    check_cycle("scan1234", {S1, S2, S3, S4}, 1'b0, 1'b1);
    frame("scan1234", {S1, S2, S3, S4}, 1'b0, 20);

    // Leading-zero blanking of 0070, loaded while scanning (cadence untouched).
    BLANK_EN = 1'b1;
    DIN      = 16'h0070;
    LOAD     = 1'b1;
    tick();
    LOAD = 1'b0;
    check_cycle("blank_on", {SD, SD, S7, S0}, 1'b0, 1'b1);
    frame("blank_on", {SD, SD, S7, S0}, 1'b0, 20);

    // Same value with blanking off: leading zeros are shown.
    BLANK_EN = 1'b0;
    frame("blank_off", {S0, S0, S7, S0}, 1'b0, 20);

    // Mid-scan update while digit 1 is lit.
    while (phase != 6) begin
      tick();
      check_cycle("pre_mid", {S0, S0, S7, S0}, 1'b0, 1'b0);
    end
    DIN  = 16'h0090;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("mid.seg9", 16'(SEG), 16'(S9));
    check_cycle("mid", {S0, S0, S9, S0}, 1'b0, 1'b1);
    frame("mid", {S0, S0, S9, S0}, 1'b0, 20);

    // Non-BCD digit, LOAD held two cycles: ACK stays high two cycles, ERR from ACK cycle.
    DIN  = 16'h12A4;
    LOAD = 1'b1;
    tick();
    check_cycle("err_ld1", {S1, S2, SD, S4}, 1'b1, 1'b1);
    tick();
    LOAD = 1'b0;
    check_cycle("err_ld2", {S1, S2, SD, S4}, 1'b1, 1'b1);
    frame("err", {S1, S2, SD, S4}, 1'b1, 20);

    // Valid content again clears ERR.
    DIN  = 16'h1294;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    check_cycle("err_clr", {S1, S2, S9, S4}, 1'b0, 1'b1);
    frame("err_clr", {S1, S2, S9, S4}, 1'b0, 10);

    // Asynchronous reset in the middle of a SHOW slot, no clock edge involved.
    while (phase % 5 == 4) begin
      tick();
      check_cycle("pre_arst", {S1, S2, S9, S4}, 1'b0, 1'b0);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_dark("arst_now");
    tick();
    RST_N = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_dark("post_arst");
    end

    // LOAD coincident with reset is ignored: no ACK, display stays OFF.
    RST_N = 1'b0;
    DIN   = 16'h5678;
    LOAD  = 1'b1;
    tick();
    check_dark("ld_in_rst");
    RST_N = 1'b1;
    LOAD  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_dark("after_ld_in_rst");
    end

    // Fresh load after reset restarts scanning at digit 0; 0005 blanked to one digit.
    BLANK_EN = 1'b1;
    DIN      = 16'h0005;
    LOAD     = 1'b1;
    tick();
    LOAD  = 1'b0;
    phase = 0;
    check_cycle("restart", {SD, SD, SD, S5}, 1'b0, 1'b1);
    frame("restart", {SD, SD, SD, S5}, 1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
